// File: rtl/lsu.sv
// lsu: load/store unit between the core memory stage and a byte-wide data RAM.
// Accepts one byte/half/word request at a time. Half and word requests are
// split into single-byte RAM accesses, lowest address first (little-endian).
// Load bytes are assembled into one value, then sign- or zero-extended.
// Exactly one response is returned per request, with an exception flag.
//
// Parameter
//   trap_misaligned : 1 = a misaligned half/word faults without touching RAM
//                     0 = a misaligned half/word is performed bytewise
// Ports
//   clk_i, rst_n_i           : clock; asynchronous active-low reset
//   req_valid_i / req_ready_o: request handshake (ready only while idle)
//   req_we_i                 : 1 = store, 0 = load
//   req_len_i                : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i           : 1 = zero-extend loads, 0 = sign-extend
//   req_addr_i, req_wdata_i  : byte address; store data (byte 0 in [7:0])
//   resp_valid_o             : one-cycle response pulse
//   resp_rdata_o             : load result (0 for stores and faults)
//   resp_exc_o               : request faulted
//   mem_rw_o, mem_addr_o     : byte write strobe and byte address to RAM
//   mem_wdata_o              : {24'b0, byte}
//   mem_rdata_i              : combinational RAM read data ([7:0] used)
//   mem_exception_i          : combinational RAM out-of-range flag
module lsu #(
  parameter bit trap_misaligned = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_len_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_exc_o,
  output logic        mem_rw_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_exception_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  len_q, len_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic        exc_q, exc_d;

  logic       misal;
  logic [1:0] last_idx;
  logic [4:0] bit_off;
  logic       sext;

  // Only the low byte of the RAM read bus carries data.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata_i[31:8];

  assign misal = (req_len_i == 2'b01 && req_addr_i[0]) ||
                 (req_len_i == 2'b10 && req_addr_i[1:0] != 2'b00);

  always_comb begin
    unique case (len_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  assign bit_off = {idx_q, 3'b000};
  assign sext    = ~uns_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      len_q   <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      len_q   <= len_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    len_d   = len_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          len_d   = req_len_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          idx_d   = '0;
          asm_d   = '0;
          exc_d   = 1'b0;
          if (req_len_i == 2'b11 || (trap_misaligned && misal)) begin
            exc_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!we_q) asm_d[bit_off +: 8] = mem_rdata_i[7:0];
        // A RAM fault ends the burst; bytes already written are left as-is.
        if (mem_exception_i) begin
          exc_d   = 1'b1;
          state_d = RESP;
        end else if (idx_q == last_idx) begin
          state_d = RESP;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM outputs decode from registered state only, so they are stable
  // for the whole ACCESS cycle and drop as soon as reset asserts.
  always_comb begin
    mem_rw_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == ACCESS) begin
      mem_rw_o    = we_q;
      mem_addr_o  = addr_q + {30'b0, idx_q};
      mem_wdata_o = {24'b0, wdata_q[bit_off +: 8]};
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_exc_o   = (state_q == RESP) && exc_q;

  always_comb begin
    resp_rdata_o = '0;
    if (state_q == RESP && !we_q && !exc_q) begin
      unique case (len_q)
        2'b00:   resp_rdata_o = {{24{sext & asm_q[7]}},  asm_q[7:0]};
        2'b01:   resp_rdata_o = {{16{sext & asm_q[15]}}, asm_q[15:0]};
        default: resp_rdata_o = asm_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. Two instances (trap_misaligned = 0 and
// 1) share one byte RAM model; sel chooses which instance is driven. A
// behavioural model computes each request's outcome from the byte-level
// rules on a shadow memory, and the bench compares the RAM access trace,
// response latency and response contents against it.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_len = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        sel = 1'b1;
  logic        fill = 1'b1;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;

  logic [1:0]  rdy, rv, rexc, mrw;
  logic [31:0] rdata [2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata [2];

  logic        req_ready, resp_valid, resp_exc, mem_rw, mem_exc;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  ram     [256];
  logic [7:0]  ref_mem [256];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lsu #(.trap_misaligned(1'b0)) u_lsu0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid && !sel), .req_ready_o(rdy[0]),
    .req_we_i(req_we), .req_len_i(req_len), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(rv[0]), .resp_rdata_o(rdata[0]), .resp_exc_o(rexc[0]),
    .mem_rw_o(mrw[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]),
    .mem_rdata_i(mem_rdata), .mem_exception_i(mem_exc)
  );

  lsu #(.trap_misaligned(1'b1)) u_lsu1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid && sel), .req_ready_o(rdy[1]),
    .req_we_i(req_we), .req_len_i(req_len), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(rv[1]), .resp_rdata_o(rdata[1]), .resp_exc_o(rexc[1]),
    .mem_rw_o(mrw[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]),
    .mem_rdata_i(mem_rdata), .mem_exception_i(mem_exc)
  );

  assign req_ready  = sel ? rdy[1]    : rdy[0];
  assign resp_valid = sel ? rv[1]     : rv[0];
  assign resp_exc   = sel ? rexc[1]   : rexc[0];
  assign resp_rdata = sel ? rdata[1]  : rdata[0];
  assign mem_rw     = sel ? mrw[1]    : mrw[0];
  assign mem_addr   = sel ? maddr[1]  : maddr[0];
  assign mem_wdata  = sel ? mwdata[1] : mwdata[0];

  // RAM: 256 bytes; anything above, or the injected fault address, faults.
  assign mem_exc   = (mem_addr >= 32'd256) || (mem_addr == fault_addr);
  assign mem_rdata = (mem_addr < 32'd256) ? {24'b0, ram[mem_addr[7:0]]} : 32'h0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (mem_rw && !mem_exc) begin
      ram[mem_addr[7:0]] <= mem_wdata[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: walk the bytes of the request in address order.
  task automatic model(input logic we, input logic [1:0] len, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic exc, output logic [31:0] rd, output int nacc);
    int n;
    logic [31:0] a, val;
    bit misal;
    n     = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    misal = (len == 2'b01 && addr[0]) || (len == 2'b10 && addr[1:0] != 2'b00);
    exc = 1'b0; val = '0; nacc = 0;
    if (len == 2'b11 || (misal && sel)) begin
      exc = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        nacc++;
        if (a >= 32'd256 || a == fault_addr) begin
          exc = 1'b1;
          break;
        end
        if (we) ref_mem[a[7:0]] = 8'((wdata >> (8 * i)) & 32'hFF);
        else    val = val | (32'(ref_mem[a[7:0]]) << (8 * i));
      end
      if (!uns && n < 4 && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
    end
    rd = (exc || we) ? 32'h0 : val;
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic do_req(input string tag, input logic we, input logic [1:0] len,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output int acc_c, output int resp_c,
                        output logic [31:0] rd_obs);
    logic e_exc;
    logic [31:0] e_rd;
    int e_n, c;
    bit got;
    model(we, len, uns, addr, wdata, e_exc, e_rd, e_n);
    req_we = we; req_len = len; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    c = 0;
    while (!req_ready && c < 10) begin @(negedge clk); c++; end
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    c = 0; got = 0; acc_c = 0;
    while (c < 10) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        acc_c = cyc;
        if (!hold) req_valid = 1'b0;
      end
      if (resp_valid) begin got = 1; break; end
      check({tag, " addr"}, mem_addr, addr + 32'(c - 1));
      check({tag, " rw"}, {31'b0, mem_rw}, {31'b0, we});
      check({tag, " wdata"}, mem_wdata, (wdata >> (8 * (c - 1))) & 32'hFF);
      check({tag, " busy"}, {31'b0, req_ready}, 32'd0);
    end
    resp_c = cyc;
    rd_obs = resp_rdata;
    check({tag, " latency"}, got ? 32'(c) : 32'd0, 32'(e_n + 1));
    check({tag, " exc"}, {31'b0, resp_exc}, {31'b0, e_exc});
    check({tag, " rdata"}, resp_rdata, e_rd);
    check({tag, " idle mem"}, {mem_rw, mem_addr[30:0]}, 32'd0);
    @(negedge clk);
    check({tag, " pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    int a0, a1, a2, r0, r1, r2;
    logic [31:0] rd;
    bit seen;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);

    // Reset state, both instances
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst ready", {31'b0, req_ready}, 32'd1);
      check("rst outs", {resp_valid, resp_exc, mem_rw, 29'b0}, 32'd0);
      check("rst rdata", resp_rdata, 32'd0);
      check("rst addr", mem_addr, 32'd0);
      check("rst wdata", mem_wdata, 32'd0);
    end
    sel = 1'b1;
    @(negedge clk);
    fill = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Word store, then loads with extension
    do_req("st word",  1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, a0, r0, rd);
    do_req("ld word",  0, 2'b10, 0, 32'h10, 32'h0, 0, a0, r0, rd);
    check("ld word val", rd, 32'hDEAD_BEEF);
    do_req("ld bs",    0, 2'b00, 0, 32'h13, 32'h0, 0, a0, r0, rd);
    check("ld bs val", rd, 32'hFFFF_FFDE);
    do_req("ld bu",    0, 2'b00, 1, 32'h13, 32'h0, 0, a0, r0, rd);
    check("ld bu val", rd, 32'h0000_00DE);
    do_req("ld hs",    0, 2'b01, 0, 32'h12, 32'h0, 0, a0, r0, rd);
    check("ld hs val", rd, 32'hFFFF_DEAD);
    do_req("ld hu",    0, 2'b01, 1, 32'h10, 32'h0, 0, a0, r0, rd);
    check("ld hu val", rd, 32'h0000_BEEF);

    // Misalignment, trapping and non-trapping
    do_req("mis trap", 0, 2'b10, 0, 32'h11, 32'h0, 0, a0, r0, rd);
    sel = 1'b0;
    do_req("mis byte", 0, 2'b10, 0, 32'h11, 32'h0, 0, a0, r0, rd);
    sel = 1'b1;

    // Illegal length, RAM fault mid-store, then read back
    do_req("len11",    0, 2'b11, 0, 32'h20, 32'h0, 0, a0, r0, rd);
    fault_addr = 32'h42;
    do_req("st fault", 1, 2'b10, 0, 32'h40, 32'h1122_3344, 0, a0, r0, rd);
    fault_addr = 32'hFFFF_FFFF;
    do_req("ld after", 0, 2'b10, 0, 32'h40, 32'h0, 0, a0, r0, rd);

    // Reset during the second ACCESS cycle of a word load
    req_we = 1'b0; req_len = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid addr", mem_addr, 32'h21);
    rst_n = 1'b0;
    #1;
    check("rst async", {mem_rw, resp_valid, 30'b0}, 32'd0);
    check("rst addr0", mem_addr, 32'd0);
    check("rst rdy", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    check("no resp", {31'b0, seen}, 32'd0);
    check("rdy after", {31'b0, req_ready}, 32'd1);

    // Back-to-back byte loads with req_valid held high
    do_req("b2b0", 0, 2'b00, 0, 32'h13, 32'h0, 1, a0, r0, rd);
    do_req("b2b1", 0, 2'b00, 1, 32'h10, 32'h0, 1, a1, r1, rd);
    do_req("b2b2", 0, 2'b00, 0, 32'h05, 32'h0, 1, a2, r2, rd);
    req_valid = 1'b0;
    check("b2b r0", 32'(r0 - a0), 32'd1);
    check("b2b r1", 32'(r1 - a0), 32'd4);
    check("b2b r2", 32'(r2 - a0), 32'd7);

    // Randomized requests against the reference
    for (int t = 0; t < 60; t++) begin
      logic [31:0] ad;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      ad = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else if (r == 1) ad = 32'd252 + $urandom_range(0, 3);
      else             ad = $urandom_range(0, 255);
      sel = $urandom_range(0, 1) == 1;
      do_req("rnd", $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, ad, $urandom, 0, a0, r0, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the core's memory stage and the byte-organised data `ram`. It accepts one byte, halfword or word request at a time and checks alignment. It then sequences the request into single-byte accesses on the `ram` port, little-endian. It assembles and sign/zero-extends load data and returns one response per request, carrying an exception flag.

## Interface
- `trap_misaligned`, default 1: 1 = misaligned half/word requests raise an exception with no RAM access; 0 = they are performed bytewise like aligned ones.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core presents a request.
- `req_ready` output 1: LSU can accept a request (high only in IDLE).
- `req_we` input 1: 1 = store, 0 = load.
- `req_len` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, byte 0 in [7:0].
- `resp_valid` output 1: one-cycle pulse, response valid.
- `resp_rdata` output 32: load result; 0 for stores and exceptions.
- `resp_exc` output 1: request faulted (misaligned, illegal length, or RAM out-of-range).
- `mem_rw` output 1: 1 = write current byte to `ram`.
- `mem_addr` output 32: byte address to `ram`.
- `mem_wdata` output 32: `{24'b0, byte}`.
- `mem_rdata` input 32: combinational read from `ram`; only [7:0] used.
- `mem_exception` input 1: combinational out-of-range flag from `ram`.

## Operation
- State machine with states IDLE, ACCESS and RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch we, len, unsigned, addr and wdata. Clear the byte index `idx` and the assembly register.
  - len=11 → RESP with exc=1.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]≠0) and `trap_misaligned`=1 → RESP with exc=1.
  - Otherwise → ACCESS. Byte count N = 1, 2 or 4.
- ACCESS (one byte per cycle)
  - Drive `mem_addr`=addr+idx (32-bit wrap).
  - Drive `mem_rw`=we.
  - Drive `mem_wdata`[7:0] = wdata byte idx.
  - Load: at the clock edge, capture `mem_rdata`[7:0] into byte idx of the assembly register.
  - If `mem_exception`=1 in any ACCESS cycle, go to RESP with exc=1. Remaining bytes are not issued. Bytes already stored stay written; no rollback.
  - Else, if idx=N-1, go to RESP. Otherwise increment idx.
- RESP
  - `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - `resp_exc` = latched exc.
  - `resp_rdata` = 0 if store or exc.
  - Otherwise, for a load:
    - Byte: `{24{s&b[7]}, b[7:0]}`.
    - Half: `{16{s&b[15]}, b[15:0]}`.
    - Word: as assembled.
    - s = ~unsigned.
- Outside ACCESS: `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0. The RAM must never see a write outside ACCESS.
- No backpressure on the response: the core must accept `resp_valid` when it pulses.

## Timing
- Reset (async, `rst_n`=0): state=IDLE; all outputs 0 except `req_ready`=1.
  - `mem_rw` drops immediately without waiting for a clock edge.
  - A reset during ACCESS abandons the request. No response is produced.
- Request accepted at edge k (state IDLE, `req_valid`=1).
  - ACCESS occupies cycles k+1 … k+N.
  - `resp_valid` is high in cycle k+N+1.
  - Next request can be accepted at edge k+N+2.
- Exception latency:
  - Alignment or illegal-length fault: `resp_valid` in cycle k+1, with no ACCESS cycles.
  - RAM fault on byte j: `resp_valid` in cycle k+j+2.
- `req_ready` is low from cycle k+1 through the RESP cycle.
- `req_*` inputs are ignored while `req_ready`=0.
- `mem_*` outputs are registered or state-decoded: stable for the whole ACCESS cycle.

## Test plan
- Word store then load:
  - Store 0xDEADBEEF @0x10 → `mem_rw` pulses at addr 0x10–0x13 with bytes EF, BE, AD, DE; `resp_valid` at k+5, exc=0.
  - Load word @0x10 → rdata 0xDEADBEEF.
- Sign/zero extension on the data above:
  - Load byte signed @0x13 → 0xFFFFFFDE.
  - Load byte unsigned @0x13 → 0x000000DE.
  - Load half signed @0x12 → 0xFFFFDEAD.
  - Load half unsigned @0x10 → 0x0000BEEF.
- Misalignment:
  - `trap_misaligned`=1, load word @0x11 → exc=1, rdata=0, `resp_valid` at k+1, no cycle with `mem_addr`≠0.
  - Same request with `trap_misaligned`=0 → bytes fetched from 0x11–0x14, exc=0.
- Illegal length and RAM fault:
  - len=11 → exc=1 at k+1.
  - Word store whose third byte raises `mem_exception` → exactly 2 byte writes, then exc=1 at k+4.
- Reset mid-word-load: assert `rst_n`=0 in the second ACCESS cycle → `mem_rw`/`mem_addr` go to 0 asynchronously, no `resp_valid`, `req_ready`=1 after release.
- Back-to-back: hold `req_valid` high with 3 byte loads → responses at k+2, k+5, k+8; each request is accepted only while `req_ready`=1.
